// File: rtl/fetch_queue.sv
// Instruction queue between fetch and decode.
// Circular buffer of {pc, insn} pairs with valid/ready handshakes on both sides.
// A flush (redirect) empties the queue in one cycle and blocks transfers while asserted.
// There is no bypass path, so an entry is visible on deq_* only from the cycle after it was written.
module fetch_queue #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 32,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush_i,
  input  logic                       enq_valid_i,
  input  logic [AWIDTH-1:0]          enq_pc_i,
  input  logic [DWIDTH-1:0]          enq_insn_i,
  output logic                       enq_ready_o,
  output logic                       deq_valid_o,
  output logic [AWIDTH-1:0]          deq_pc_o,
  output logic [DWIDTH-1:0]          deq_insn_o,
  input  logic                       deq_ready_i,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [AWIDTH-1:0] pc_q   [DEPTH];
  logic [AWIDTH-1:0] pc_d   [DEPTH];
  logic [DWIDTH-1:0] insn_q [DEPTH];
  logic [DWIDTH-1:0] insn_d [DEPTH];
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]     count_q, count_d;

  logic full, empty, enq_fire, deq_fire;

  // Handshake outputs; reset and flush both block any transfer.
  // Data and count are forced to zero while reset is held.
  always_comb begin
    full        = (count_q == CW'(DEPTH));
    empty       = (count_q == '0);
    enq_ready_o = rst & ~flush_i & ~full;
    deq_valid_o = rst & ~flush_i & ~empty;
    enq_fire    = enq_valid_i & enq_ready_o;
    deq_fire    = deq_valid_o & deq_ready_i;
    deq_pc_o    = rst ? pc_q[rd_ptr_q]   : '0;
    deq_insn_o  = rst ? insn_q[rd_ptr_q] : '0;
    count_o     = rst ? count_q          : '0;
  end

  // Next state: flush rewinds pointers and count but leaves storage as is.
  always_comb begin
    pc_d     = pc_q;
    insn_d   = insn_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (enq_fire) begin
        pc_d[wr_ptr_q]   = enq_pc_i;
        insn_d[wr_ptr_q] = enq_insn_i;
        wr_ptr_d         = wr_ptr_q + PW'(1);
      end
      if (deq_fire) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      count_d = count_q + CW'(enq_fire) - CW'(deq_fire);
    end
  end

  // State registers with synchronous active-low reset clearing everything, storage included.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i]   <= '0;
        insn_q[i] <= '0;
      end
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      pc_q     <= pc_d;
      insn_q   <= insn_d;
    end
  end

  // Occupancy never exceeds capacity; no enqueue into a full queue, no dequeue from an empty one.
  a_count_max: assert property (@(posedge clk) disable iff (!rst) count_q <= CW'(DEPTH));
  a_no_enq_full: assert property (@(posedge clk) disable iff (!rst) enq_fire |-> !full);
  a_no_deq_empty: assert property (@(posedge clk) disable iff (!rst) deq_fire |-> !empty);

endmodule
